// File: rtl/dphy_pkg.sv
// rtl/dphy_pkg.sv - shared constants for the D-PHY LP receive lane
package dphy_pkg;

  localparam logic [1:0] LP_00 = 2'b00;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_10 = 2'b10;
  localparam logic [1:0] LP_11 = 2'b11;

  localparam logic [3:0] ST_STOP      = 4'd0;
  localparam logic [3:0] ST_HS_RQST   = 4'd1;
  localparam logic [3:0] ST_HS_ACTIVE = 4'd2;
  localparam logic [3:0] ST_ESC_RQST  = 4'd3;
  localparam logic [3:0] ST_ESC_GO    = 4'd4;
  localparam logic [3:0] ST_ESC_ACK   = 4'd5;
  localparam logic [3:0] ST_ESC_SPACE = 4'd6;
  localparam logic [3:0] ST_ESC_MARK  = 4'd7;
  localparam logic [3:0] ST_ERR       = 4'd8;

  localparam int LP_FILTER_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/dphy_lp_filter.sv
// rtl/dphy_lp_filter.sv - LP line synchronizer, optional P/N swap and deglitch filter
module dphy_lp_filter
  import dphy_pkg::*;
#(
  parameter int g_sync_stages   = 2,
  parameter int g_filter_cycles = LP_FILTER_CYCLES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       lp_rxp_i,
  input  logic       lp_rxn_i,
  input  logic       lane_invert_i,
  output logic [1:0] fs_o,
  output logic       fs_chg_o
);

  localparam logic [3:0] FILT_N = 4'(g_filter_cycles);

  logic [g_sync_stages-1:0] p_sync_q, p_sync_d;
  logic [g_sync_stages-1:0] n_sync_q, n_sync_d;
  logic [1:0] smp;
  logic [1:0] cand_q, cand_d;
  logic [1:0] fs_q, fs_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_nxt;
  logic       chg_q, chg_d;

  always_comb begin
    p_sync_d = {p_sync_q[g_sync_stages-2:0], lp_rxp_i};
    n_sync_d = {n_sync_q[g_sync_stages-2:0], lp_rxn_i};
    smp      = lane_invert_i ? {n_sync_q[g_sync_stages-1], p_sync_q[g_sync_stages-1]}
                             : {p_sync_q[g_sync_stages-1], n_sync_q[g_sync_stages-1]};
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    fs_d     = fs_q;
    chg_d    = 1'b0;
    cnt_nxt  = 4'd0;
    if (smp == fs_q) begin
      cnt_d = 4'd0;
    end else begin
      // A sample that disagrees with the running candidate restarts the count
      cnt_nxt = (cnt_q == 4'd0 || smp != cand_q) ? 4'd1 : cnt_q + 4'd1;
      cand_d  = smp;
      if (cnt_nxt >= FILT_N) begin
        fs_d  = smp;
        cnt_d = 4'd0;
        chg_d = 1'b1;
      end else begin
        cnt_d = cnt_nxt;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_sync_q <= '1;
      n_sync_q <= '1;
      cand_q   <= LP_11;
      fs_q     <= LP_11;
      cnt_q    <= 4'd0;
      chg_q    <= 1'b0;
    end else begin
      p_sync_q <= p_sync_d;
      n_sync_q <= n_sync_d;
      cand_q   <= cand_d;
      fs_q     <= fs_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
    end
  end

  assign fs_o     = fs_q;
  assign fs_chg_o = chg_q;

endmodule

// File: rtl/dphy_lp_rx_lane.sv
// rtl/dphy_lp_rx_lane.sv - D-PHY data lane LP receiver: LP state FSM, HS entry and LPDT byte decode
module dphy_lp_rx_lane
  import dphy_pkg::*;
#(
  parameter int g_sync_stages   = 2,
  parameter int g_filter_cycles = LP_FILTER_CYCLES_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       lp_rxp_i,
  input  logic       lp_rxn_i,
  input  logic       lane_invert_i,
  output logic [7:0] lp_data_o,
  output logic       lp_valid_o,
  output logic       lpdt_active_o,
  output logic       lpdt_done_o,
  output logic       hs_active_o,
  output logic       stop_o,
  output logic       err_o,
  output logic [1:0] line_state_o
);

  logic [1:0] fs;
  logic       fs_chg;

  dphy_lp_filter #(
    .g_sync_stages  (g_sync_stages),
    .g_filter_cycles(g_filter_cycles)
  ) u_filter (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .lp_rxp_i     (lp_rxp_i),
    .lp_rxn_i     (lp_rxn_i),
    .lane_invert_i(lane_invert_i),
    .fs_o         (fs),
    .fs_chg_o     (fs_chg)
  );

  logic [3:0] state_q, state_d;
  logic       bit_q, bit_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       hs_q, hs_d;
  logic       stop_q, stop_d;
  logic       lpdt_q, lpdt_d;

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (fs_chg) begin
      case (state_q)
        ST_STOP: begin
          if (fs == LP_01)      state_d = ST_HS_RQST;
          else if (fs == LP_10) state_d = ST_ESC_RQST;
          else if (fs == LP_00) begin state_d = ST_ERR; err_d = 1'b1; end
        end
        ST_HS_RQST: begin
          if (fs == LP_00)      state_d = ST_HS_ACTIVE;
          else if (fs == LP_11) state_d = ST_STOP;
          else if (fs == LP_10) begin state_d = ST_ERR; err_d = 1'b1; end
        end
        ST_HS_ACTIVE: begin
          if (fs == LP_11) state_d = ST_STOP;
        end
        ST_ESC_RQST: begin
          if (fs == LP_00)      state_d = ST_ESC_GO;
          else if (fs == LP_11) state_d = ST_STOP;
          else if (fs == LP_01) begin state_d = ST_ERR; err_d = 1'b1; end
        end
        ST_ESC_GO: begin
          if (fs == LP_01)      state_d = ST_ESC_ACK;
          else if (fs == LP_11) state_d = ST_STOP;
          else if (fs == LP_10) begin state_d = ST_ERR; err_d = 1'b1; end
        end
        ST_ESC_ACK: begin
          if (fs == LP_00)      state_d = ST_ESC_SPACE;
          else if (fs == LP_11) state_d = ST_STOP;
          else if (fs == LP_10) begin state_d = ST_ERR; err_d = 1'b1; end
        end
        ST_ESC_SPACE: begin
          if (fs == LP_10)      begin state_d = ST_ESC_MARK; bit_d = 1'b1; end
          else if (fs == LP_01) begin state_d = ST_ESC_MARK; bit_d = 1'b0; end
          else if (fs == LP_11) begin state_d = ST_STOP; err_d = 1'b1; end
        end
        ST_ESC_MARK: begin
          if (fs == LP_00) begin
            shreg_d   = {shreg_q[6:0], bit_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d  = {shreg_q[6:0], bit_q};
              valid_d = 1'b1;
            end
            state_d = ST_ESC_SPACE;
          end else if (fs == LP_11) begin
            // Only a mark-one followed by 11 on a byte boundary is a clean exit
            if (bit_q && bit_cnt_q == 3'd0) done_d = 1'b1;
            else                            err_d  = 1'b1;
            state_d = ST_STOP;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_ERR: begin
          if (fs == LP_11) state_d = ST_STOP;
        end
        default: state_d = ST_STOP;
      endcase
    end
    if (state_d != ST_ESC_SPACE && state_d != ST_ESC_MARK) begin
      shreg_d   = 8'd0;
      bit_cnt_d = 3'd0;
    end
    hs_d   = (state_d == ST_HS_ACTIVE);
    stop_d = (state_d == ST_STOP);
    lpdt_d = (state_d == ST_ESC_SPACE) || (state_d == ST_ESC_MARK);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_STOP;
      bit_q     <= 1'b0;
      bit_cnt_q <= 3'd0;
      shreg_q   <= 8'd0;
      data_q    <= 8'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      hs_q      <= 1'b0;
      stop_q    <= 1'b1;
      lpdt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      hs_q      <= hs_d;
      stop_q    <= stop_d;
      lpdt_q    <= lpdt_d;
    end
  end

  assign lp_data_o     = data_q;
  assign lp_valid_o    = valid_q;
  assign lpdt_active_o = lpdt_q;
  assign lpdt_done_o   = done_q;
  assign hs_active_o   = hs_q;
  assign stop_o        = stop_q;
  assign err_o         = err_q;
  assign line_state_o  = fs;

endmodule

// File: tb/tb_dphy_lp_rx_lane.sv
// tb/tb_dphy_lp_rx_lane.sv - directed bench for dphy_lp_rx_lane
module tb_dphy_lp_rx_lane;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lp_rxp = 1'b1;
  logic       lp_rxn = 1'b1;
  logic       lane_invert = 1'b0;
  logic [7:0] lp_data;
  logic       lp_valid, lpdt_active, lpdt_done, hs_active, stop, err;
  logic [1:0] line_state;

  dphy_lp_rx_lane dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .lp_rxp_i     (lp_rxp),
    .lp_rxn_i     (lp_rxn),
    .lane_invert_i(lane_invert),
    .lp_data_o    (lp_data),
    .lp_valid_o   (lp_valid),
    .lpdt_active_o(lpdt_active),
    .lpdt_done_o  (lpdt_done),
    .hs_active_o  (hs_active),
    .stop_o       (stop),
    .err_o        (err),
    .line_state_o (line_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_done = 0, n_err = 0, n_both = 0;
  int last_valid_cyc = -1, hs_rise_cyc = -1, hs_fall_cyc = -1;
  logic hs_prev = 1'b0;

  always @(negedge clk) begin
    if (lp_valid) begin n_valid++; last_valid_cyc = cyc; end
    if (lpdt_done) n_done++;
    if (err) n_err++;
    if (lp_valid && lpdt_done) n_both++;
    if (hs_active && !hs_prev) hs_rise_cyc = cyc;
    if (!hs_active && hs_prev) hs_fall_cyc = cyc;
    hs_prev = hs_active;
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic inv = 1'b0;
  int   drv_cyc = 0;
  int   space_cyc = 0;

  task automatic drive(input logic p, input logic n, input int hold);
    lp_rxp  = inv ? n : p;
    lp_rxn  = inv ? p : n;
    drv_cyc = cyc;
    repeat (hold) @(negedge clk);
  endtask

  task automatic esc_entry();
    drive(1'b1, 1'b0, 20);
    drive(1'b0, 1'b0, 20);
    drive(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0, 20);
  endtask

  task automatic send_bits(input logic [7:0] val, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      drive(val[7-i], ~val[7-i], 20);
      drive(1'b0, 1'b0, 0);
      space_cyc = drv_cyc;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic esc_exit();
    drive(1'b1, 1'b0, 20);
    drive(1'b1, 1'b1, 20);
  endtask

  int v0, d0, e0;

  task automatic snap();
    v0 = n_valid; d0 = n_done; e0 = n_err;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_stop", int'(stop), 1);
    check("rst_line_state", int'(line_state), 3);
    check("rst_data", int'(lp_data), 0);
    check("rst_flags", int'({lp_valid, lpdt_active, lpdt_done, hs_active, err}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Escape carrying 0xA5 with a clean exit
    snap();
    esc_entry();
    check("a5_lpdt_active", int'(lpdt_active), 1);
    send_bits(8'hA5, 8);
    esc_exit();
    repeat (20) @(negedge clk);
    check("a5_valid_count", n_valid - v0, 1);
    check("a5_data", int'(lp_data), 'hA5);
    check("a5_valid_latency", last_valid_cyc - space_cyc, 7);
    check("a5_done_count", n_done - d0, 1);
    check("a5_err_count", n_err - e0, 0);
    check("a5_stop", int'(stop), 1);
    check("a5_lpdt_idle", int'(lpdt_active), 0);

    // HS entry and return to stop
    snap();
    drive(1'b0, 1'b1, 20);
    drive(1'b0, 1'b0, 100);
    begin
      int c00;
      c00 = drv_cyc;
      check("hs_active_mid", int'(hs_active), 1);
      check("hs_stop_low", int'(stop), 0);
      repeat (100) @(negedge clk);
      drive(1'b1, 1'b1, 20);
      check("hs_rise_latency", hs_rise_cyc - c00, 7);
    end
    check("hs_fall_latency", hs_fall_cyc - drv_cyc, 7);
    check("hs_stop_back", int'(stop), 1);
    check("hs_no_strobes", (n_valid - v0) + (n_done - d0) + (n_err - e0), 0);

    // Exit after three bits is a partial byte
    snap();
    esc_entry();
    send_bits(8'b1010_0000, 3);
    esc_exit();
    repeat (20) @(negedge clk);
    check("partial_err", n_err - e0, 1);
    check("partial_no_valid", n_valid - v0, 0);
    check("partial_no_done", n_done - d0, 0);
    check("partial_data_kept", int'(lp_data), 'hA5);
    check("partial_stop", int'(stop), 1);

    // 3-clock glitch rejected, 4-clock pulse taken as a one bit
    snap();
    esc_entry();
    drive(1'b1, 1'b0, 3);
    drive(1'b0, 1'b0, 20);
    check("glitch_still_lpdt", int'(lpdt_active), 1);
    drive(1'b1, 1'b0, 4);
    drive(1'b0, 1'b0, 20);
    send_bits(8'h02, 7);
    esc_exit();
    repeat (20) @(negedge clk);
    check("glitch_data", int'(lp_data), 'h81);
    check("glitch_valid_count", n_valid - v0, 1);
    check("glitch_err_count", n_err - e0, 0);
    check("glitch_done_count", n_done - d0, 1);

    // Inverted lane polarity
    snap();
    inv = 1'b1;
    lane_invert = 1'b1;
    repeat (10) @(negedge clk);
    esc_entry();
    send_bits(8'h3C, 8);
    esc_exit();
    repeat (20) @(negedge clk);
    check("inv_data", int'(lp_data), 'h3C);
    check("inv_done_count", n_done - d0, 1);
    check("inv_err_count", n_err - e0, 0);
    inv = 1'b0;
    lane_invert = 1'b0;
    repeat (10) @(negedge clk);

    // Async reset mid-byte, then a clean 0x01
    snap();
    esc_entry();
    send_bits(8'hF0, 4);
    check("mid_lpdt_active", int'(lpdt_active), 1);
    #2;
    rst    = 1'b1;
    lp_rxp = 1'b1;
    lp_rxn = 1'b1;
    #1;
    check("arst_data", int'(lp_data), 0);
    check("arst_stop", int'(stop), 1);
    check("arst_lpdt", int'(lpdt_active), 0);
    check("arst_line_state", int'(line_state), 3);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("arst_no_err", n_err - e0, 0);
    esc_entry();
    send_bits(8'h01, 8);
    esc_exit();
    repeat (20) @(negedge clk);
    check("post_rst_data", int'(lp_data), 'h01);
    check("post_rst_done", n_done - d0, 1);

    check("valid_done_overlap", n_both, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
